// File: rtl/mm_accumulate_store.sv
// mm_accumulate_store
//   Multiply-accumulate stage behind the matrix-multiply address controller.
//   It aligns the controller strobes with the synchronous X/A memory read
//   data, which arrives one cycle after each address. It accumulates the
//   operand products, commits each finished dot product into a 16-entry flop
//   buffer, and raises done once NUM_RESULTS results have been stored. After
//   that the buffer can be read back one word per cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a new run (buffer kept)
//   acc_en              operand address issued this cycle
//   result_en, addr_p   commit the current dot product to index addr_p
//   x_data, a_data      memory read data, valid the cycle after acc_en
//   p_wr, p_wr_addr,
//   p_wr_data           registered copy of each buffer write
//   done                all NUM_RESULTS results stored (level)
//   rd_req, rd_addr     read request, honoured only while done=1
//   rd_valid, rd_data   read response, one cycle after rd_req
module mm_accumulate_store #(
  parameter int DW          = 8,
  parameter int AW          = 2*DW+3,
  parameter int NUM_RESULTS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_en,
  input  logic          result_en,
  input  logic [3:0]    addr_p,
  input  logic [DW-1:0] x_data,
  input  logic [DW-1:0] a_data,
  output logic          p_wr,
  output logic [3:0]    p_wr_addr,
  output logic [AW-1:0] p_wr_data,
  output logic          done,
  input  logic          rd_req,
  input  logic [3:0]    rd_addr,
  output logic          rd_valid,
  output logic [AW-1:0] rd_data
);

  localparam logic [4:0] NR = 5'(NUM_RESULTS);

  // Alignment registers: strobes delayed to line up with the read data.
  logic          acc_en_d;
  logic          res_en_d;
  logic [3:0]    addr_p_d;

  logic [AW-1:0]   acc;
  logic [2*DW-1:0] prod_raw;
  logic [AW-1:0]   prod;
  logic [4:0]      wcnt;
  logic [4:0]      wcnt_nxt;
  logic            commit;
  logic [AW-1:0]   buf_q [16];

  assign prod_raw = {{DW{1'b0}}, x_data} * {{DW{1'b0}}, a_data};
  assign prod     = AW'(prod_raw);

  // A start pulse drops any commit that is in flight in the same cycle.
  assign commit   = res_en_d & ~start;
  assign wcnt_nxt = (wcnt == NR) ? wcnt : wcnt + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_en_d  <= 1'b0;
      res_en_d  <= 1'b0;
      addr_p_d  <= '0;
      acc       <= '0;
      wcnt      <= '0;
      done      <= 1'b0;
      p_wr      <= 1'b0;
      p_wr_addr <= '0;
      p_wr_data <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      acc_en_d <= acc_en & ~start;
      res_en_d <= result_en & ~start;
      addr_p_d <= start ? 4'd0 : addr_p;

      p_wr <= commit;
      if (commit) begin
        p_wr_addr       <= addr_p_d;
        p_wr_data       <= acc;
        buf_q[addr_p_d] <= acc;
        wcnt            <= wcnt_nxt;
        done            <= (wcnt_nxt == NR);
      end

      // When a commit and the next element's first product coincide, the
      // product must start the new sum (load), not add to the committed one.
      if (start) begin
        acc  <= '0;
        wcnt <= '0;
        done <= 1'b0;
      end else if (res_en_d && acc_en_d) begin
        acc <= prod;
      end else if (res_en_d) begin
        acc <= '0;
      end else if (acc_en_d) begin
        acc <= acc + prod;
      end

      // A read samples buf_q before this cycle's commit lands (old data).
      rd_valid <= rd_req & done;
      if (rd_req && done) rd_data <= buf_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_mm_accumulate_store.sv
module tb_mm_accumulate_store;

  logic        clk, rst, start, acc_en, result_en, rd_req;
  logic [3:0]  addr_p, rd_addr, p_wr_addr;
  logic [7:0]  x_data, a_data;
  logic        p_wr, done, rd_valid;
  logic [18:0] p_wr_data, rd_data;

  mm_accumulate_store dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en), .result_en(result_en),
    .addr_p(addr_p), .x_data(x_data), .a_data(a_data), .p_wr(p_wr),
    .p_wr_addr(p_wr_addr), .p_wr_data(p_wr_data), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [18:0] d;
    logic        dn;
  } wr_t;

  wr_t         expq[$];
  logic [18:0] rdq[$];
  int          nvec = 0;
  int          nfail = 0;

  // Reference model: per-element running dot product, buffer image, count.
  logic [18:0] mbuf [16];
  logic [18:0] cur_sum;
  bit          pend;
  logic [3:0]  pend_addr;
  int          cnt;
  logic [7:0]  nx, na;   // memory data to present on the next cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or read.
  wr_t         me;
  logic [18:0] mr;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_wr) begin
        if (expq.size() == 0) chk("p_wr_unexpected", 1, 0);
        else begin
          me = expq.pop_front();
          chk("p_wr_addr", p_wr_addr, me.a);
          chk("p_wr_data", p_wr_data, me.d);
          chk("done_at_wr", done, me.dn);
        end
      end
      if (rd_valid) begin
        if (rdq.size() == 0) chk("rd_valid_unexpected", 1, 0);
        else begin
          mr = rdq.pop_front();
          chk("rd_data", rd_data, mr);
        end
      end
    end
  end

  function automatic void commit_model(input logic [3:0] ad, input logic [18:0] v);
    wr_t e;
    mbuf[ad] = v;
    if (cnt < 16) cnt++;
    e.a = ad; e.d = v; e.dn = (cnt == 16);
    expq.push_back(e);
  endfunction

  task automatic step(input bit ae, input bit re, input logic [3:0] ad,
                      input logic [7:0] xv, input logic [7:0] av);
    acc_en = ae; result_en = re; addr_p = ad; x_data = nx; a_data = na;
    nx = ae ? xv : 8'($urandom);
    na = ae ? av : 8'($urandom);
    @(negedge clk);
  endtask

  // Issues n operand addresses; the first one also carries the pending
  // result_en of the previous element when no flush separated them.
  task automatic element(input logic [3:0] ad, input int n, input logic [7:0] fx,
                         input logic [7:0] fa, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [7:0] xv, av;
      bit         re;
      logic [3:0] ra;
      xv = rnd ? 8'($urandom) : fx;
      av = rnd ? 8'($urandom) : fa;
      re = 0; ra = 4'($urandom);
      if (i == 0 && pend) begin
        re = 1; ra = pend_addr;
        commit_model(pend_addr, cur_sum);
        cur_sum = '0; pend = 0;
      end
      cur_sum = cur_sum + ({11'b0, xv} * {11'b0, av});
      step(1, re, ra, xv, av);
    end
    pend = 1; pend_addr = ad;
  endtask

  task automatic flush();
    logic [3:0] ad;
    if (pend) begin
      ad = pend_addr;
      commit_model(ad, cur_sum);
      cur_sum = '0; pend = 0;
      step(0, 1, ad, 0, 0);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 4'($urandom), 0, 0);
  endtask

  task automatic do_start();
    start = 1; step(0, 0, 4'($urandom), 0, 0); start = 0;
    cnt = 0; cur_sum = '0; pend = 0;
    chk("done_after_start", done, 0);
  endtask

  task automatic rd(input logic [3:0] ad);
    rd_req = 1; rd_addr = ad;
    if (cnt == 16) rdq.push_back(mbuf[ad]);
    step(0, 0, 4'($urandom), 0, 0);
    rd_req = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_p_wr"}, p_wr, 0);
    chk({tag, "_p_wr_addr"}, p_wr_addr, 0);
    chk({tag, "_p_wr_data"}, p_wr_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mbuf[i] = '0;
    cur_sum = '0; pend = 0; cnt = 0;
  endfunction

  initial begin
    clk = 0; rst = 1; start = 0; acc_en = 0; result_en = 0; addr_p = 0;
    x_data = 0; a_data = 0; rd_req = 0; rd_addr = 0; nx = 0; na = 0;
    model_reset();
    @(negedge clk);
    idle(2);
    chk_reset_outputs("reset");
    rst = 0;

    // Single element 1*2 x5 -> 10 at index 3.
    element(3, 5, 1, 2, 0); flush(); idle(3);
    chk("done_single", done, 0);

    // Full-scale terms, must not wrap.
    element(4, 5, 255, 255, 0); flush(); idle(3);

    // Controller pattern back-to-back, then overlapped commit/load.
    element(0, 5, 1, 1, 0); flush(); element(1, 5, 2, 3, 0); flush(); idle(2);
    element(5, 3, 7, 9, 0); element(6, 4, 11, 13, 0); flush(); idle(3);

    // Read while not done is ignored.
    rd(2);
    chk("rd_valid_notdone", rd_valid, 0);
    idle(1);

    // Full run of 16 elements, then back-to-back readout.
    do_start();
    for (int k = 0; k < 16; k++) begin
      element(4'(k), 5, 8'(k), 1, 0); flush();
    end
    idle(3);
    chk("done_full", done, 1);
    for (int k = 0; k < 16; k++) rd(4'(k));
    idle(2);

    // Random elements with mixed overlap/flush/gaps; commits past done.
    for (int k = 0; k < 20; k++) begin
      element(4'($urandom), $urandom_range(1, 8), 0, 0, 1);
      case ($urandom_range(0, 2))
        0: ;
        1: flush();
        default: begin flush(); idle($urandom_range(1, 3)); end
      endcase
    end
    flush(); idle(3);
    for (int k = 0; k < 16; k++) rd(4'(k));
    idle(2);

    // New run touching only indices 0..7; 8..15 keep the old values.
    do_start();
    for (int k = 0; k < 16; k++) begin
      element(4'($urandom_range(0, 7)), $urandom_range(1, 8), 0, 0, 1);
      if ($urandom_range(0, 1) == 1) flush();
    end
    flush(); idle(3);
    chk("done_rerun", done, 1);
    for (int k = 0; k < 16; k++) rd(4'(k));
    idle(2);

    // Reset in the middle of an element.
    element(9, 3, 0, 0, 1);
    rst = 1; pend = 0;
    step(0, 0, 0, 0, 0);
    chk_reset_outputs("midrst");
    rst = 0;
    model_reset();
    element(9, 4, 3, 5, 0); flush(); idle(3);
    chk("done_after_rst", done, 0);

    chk("expq_drained", expq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
